// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side master for the registered 16-bit ALU.
// Accepts one command at a time over CMD_VALID/CMD_READY and drives the
// ALU operand and function inputs. It waits out the ALU's one-cycle
// registered latency, captures the result and category flags, and returns
// them over RES_VALID/RES_READY.
// It also traps divide-by-zero and opcode 4'b1111 without driving the ALU.
// It keeps an accumulator for chained ops and counts completed results.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   CMD_VALID/READY           command handshake
//   CMD_FUN/A/B/USE_ACC       command payload
//   ALU_A/B/FUN               registered drive into the ALU
//   ALU_RES, ALU_* flags      ALU outputs, one cycle after issue
//   RES_VALID/READY           result handshake
//   RES_DATA/FLAGS/ERR        captured result; flags are {carry,arith,logic,cmp,shift}
//   OP_COUNT                  completed result handshakes (wraps)
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [3:0]       CMD_FUN,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic             CMD_USE_ACC,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_RES,
  input  logic             ALU_CARRY,
  input  logic             ALU_ARITH,
  input  logic             ALU_LOGIC,
  input  logic             ALU_CMP,
  input  logic             ALU_SHIFT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic [4:0]       RES_FLAGS,
  output logic             RES_ERR,
  output logic [CNT_W-1:0] OP_COUNT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] FUN_ADD = 4'b0000;
  localparam logic [3:0] FUN_SUB = 4'b0001;
  localparam logic [3:0] FUN_DIV = 4'b0011;
  localparam logic [3:0] FUN_NOP = 4'b1111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [4:0]       res_flags_q, res_flags_d;
  logic             res_err_q, res_err_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a;
  logic             carry_q;

  assign op_a = CMD_USE_ACC ? acc_q : CMD_A;
  // The ALU leaves its carry output stale for anything but add/sub.
  // alu_fun_q still holds the issued op during WAIT.
  assign carry_q = ((alu_fun_q == FUN_ADD) || (alu_fun_q == FUN_SUB)) ? ALU_CARRY : 1'b0;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          if ((CMD_FUN == FUN_DIV) && (CMD_B == '0)) begin
            res_data_d  = '1;
            res_flags_d = '0;
            res_err_d   = 1'b1;
            state_d     = S_RESP;
          end else if (CMD_FUN == FUN_NOP) begin
            res_data_d  = '0;
            res_flags_d = '0;
            res_err_d   = 1'b1;
            state_d     = S_RESP;
          end else begin
            // Operand registers are the ALU drive itself.
            // This makes them valid throughout ISSUE, and the ALU's
            // registered result is then present during WAIT.
            alu_a_d   = op_a;
            alu_b_d   = CMD_B;
            alu_fun_d = CMD_FUN;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        res_data_d  = ALU_RES;
        res_flags_d = {carry_q, ALU_ARITH, ALU_LOGIC, ALU_CMP, ALU_SHIFT};
        res_err_d   = 1'b0;
        acc_d       = ALU_RES;
        alu_fun_d   = FUN_NOP;
        state_d     = S_RESP;
      end
      default: begin
        if (RES_READY) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FUN_NOP;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign RES_VALID = (state_q == S_RESP);
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign RES_DATA  = res_data_q;
  assign RES_FLAGS = res_flags_q;
  assign RES_ERR   = res_err_q;
  assign OP_COUNT  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered ALU stand-in.
// Counter width is 4 so that wrap is reachable in a short run.
module tb_alu_cmd_sequencer;
  localparam int W = 16;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CMD_VALID, CMD_READY, CMD_USE_ACC;
  logic [3:0]    CMD_FUN;
  logic [W-1:0]  CMD_A, CMD_B;
  logic [W-1:0]  ALU_A, ALU_B, ALU_RES;
  logic [3:0]    ALU_FUN;
  logic          ALU_CARRY, ALU_ARITH, ALU_LOGIC, ALU_CMP, ALU_SHIFT;
  logic          RES_VALID, RES_READY, RES_ERR;
  logic [W-1:0]  RES_DATA;
  logic [4:0]    RES_FLAGS;
  logic [CW-1:0] OP_COUNT;

  int n_chk = 0;
  int n_pass = 0;
  int lat;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FUN(CMD_FUN),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_USE_ACC(CMD_USE_ACC),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_RES(ALU_RES),
    .ALU_CARRY(ALU_CARRY), .ALU_ARITH(ALU_ARITH), .ALU_LOGIC(ALU_LOGIC),
    .ALU_CMP(ALU_CMP), .ALU_SHIFT(ALU_SHIFT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_FLAGS(RES_FLAGS), .RES_ERR(RES_ERR), .OP_COUNT(OP_COUNT)
  );

  // Registered ALU stand-in. For non add/sub ops, carry is deliberately
  // left high. This mimics the stale carry that the sequencer must mask.
  always_ff @(posedge CLK) begin
    ALU_CARRY <= 1'b1;
    ALU_ARITH <= 1'b0;
    ALU_LOGIC <= 1'b0;
    ALU_CMP   <= 1'b0;
    ALU_SHIFT <= 1'b0;
    case (ALU_FUN)
      4'b0000: begin {ALU_CARRY, ALU_RES} <= {1'b0, ALU_A} + {1'b0, ALU_B}; ALU_ARITH <= 1'b1; end
      4'b0001: begin ALU_RES <= ALU_A - ALU_B; ALU_CARRY <= (ALU_A < ALU_B); ALU_ARITH <= 1'b1; end
      4'b0010: begin ALU_RES <= ALU_A * ALU_B; ALU_ARITH <= 1'b1; end
      4'b0011: begin ALU_RES <= (ALU_B == 0) ? 16'hFFFF : ALU_A / ALU_B; ALU_ARITH <= 1'b1; end
      4'b1011: begin ALU_RES <= (ALU_A > ALU_B) ? 16'd2 : ((ALU_A == ALU_B) ? 16'd1 : 16'd0); ALU_CMP <= 1'b1; end
      default: begin ALU_RES <= ALU_A & ALU_B; ALU_LOGIC <= 1'b1; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called on a falling edge. It returns on the falling edge at which
  // RES_VALID is first seen high. lat counts rising edges from the accept
  // edge onward, inclusive.
  task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ua, output int l);
    CMD_FUN = f; CMD_A = a; CMD_B = b; CMD_USE_ACC = ua; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    l = 1;
    while (!RES_VALID && l < 12) begin
      @(negedge CLK);
      l++;
    end
  endtask

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_FUN = 4'b0; CMD_A = '0; CMD_B = '0;
    CMD_USE_ACC = 1'b0; RES_READY = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk("rst_cmd_ready", CMD_READY, 1);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_alu_fun", ALU_FUN, 4'hF);
    chk("rst_alu_a", ALU_A, 0);
    chk("rst_res_data", RES_DATA, 0);
    chk("rst_op_count", OP_COUNT, 0);

    // ADD with carry out
    issue(4'b0000, 16'hFFFF, 16'h0001, 1'b0, lat);
    chk("add_lat", lat, 3);
    chk("add_data", RES_DATA, 16'h0000);
    chk("add_flags", RES_FLAGS, 5'b11000);
    chk("add_err", RES_ERR, 0);
    chk("add_alu_fun_idle", ALU_FUN, 4'hF);
    @(negedge CLK);
    chk("add_count", OP_COUNT, 1);
    chk("add_ready", CMD_READY, 1);

    // MUL, then SUB chained off the accumulator
    issue(4'b0010, 16'd3, 16'd5, 1'b0, lat);
    chk("mul_data", RES_DATA, 16'd15);
    chk("mul_flags", RES_FLAGS, 5'b01000);
    @(negedge CLK);
    issue(4'b0001, 16'hDEAD, 16'd4, 1'b1, lat);
    chk("chain_data", RES_DATA, 16'd11);
    chk("chain_flags", RES_FLAGS, 5'b01000);
    @(negedge CLK);

    // Divide by zero is trapped and leaves the accumulator alone
    issue(4'b0011, 16'd7, 16'd0, 1'b0, lat);
    chk("div0_lat", lat, 1);
    chk("div0_data", RES_DATA, 16'hFFFF);
    chk("div0_flags", RES_FLAGS, 0);
    chk("div0_err", RES_ERR, 1);
    chk("div0_alu_fun", ALU_FUN, 4'hF);
    @(negedge CLK);
    issue(4'b0000, 16'd0, 16'd0, 1'b1, lat);
    chk("acc_kept", RES_DATA, 16'd11);
    chk("acc_kept_err", RES_ERR, 0);
    @(negedge CLK);

    // Illegal opcode
    issue(4'b1111, 16'd1, 16'd1, 1'b0, lat);
    chk("ill_lat", lat, 1);
    chk("ill_data", RES_DATA, 0);
    chk("ill_err", RES_ERR, 1);
    @(negedge CLK);
    chk("ill_count", OP_COUNT, 6);

    // Backpressure on CMP; a second command offered meanwhile is ignored
    RES_READY = 1'b0;
    issue(4'b1011, 16'd9, 16'd2, 1'b0, lat);
    chk("cmp_lat", lat, 3);
    CMD_FUN = 4'b0000; CMD_A = 16'd1; CMD_B = 16'd1; CMD_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_valid", RES_VALID, 1);
      chk("bp_data", RES_DATA, 16'd2);
      chk("bp_flags", RES_FLAGS, 5'b00010);
      chk("bp_cmd_ready", CMD_READY, 0);
    end
    CMD_VALID = 1'b0;
    RES_READY = 1'b1;
    @(negedge CLK);
    chk("bp_done_valid", RES_VALID, 0);
    chk("bp_count", OP_COUNT, 7);
    @(negedge CLK);
    chk("bp_no_ghost", RES_VALID, 0);

    // Reset during WAIT
    CMD_FUN = 4'b0000; CMD_A = 16'd2; CMD_B = 16'd3; CMD_USE_ACC = 1'b0; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("mid_alu_fun_issued", ALU_FUN, 4'b0000);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_valid", RES_VALID, 0);
    chk("mid_rst_ready", CMD_READY, 1);
    chk("mid_rst_count", OP_COUNT, 0);
    chk("mid_rst_alu_fun", ALU_FUN, 4'hF);
    chk("mid_rst_alu_b", ALU_B, 0);
    chk("mid_rst_data", RES_DATA, 0);
    chk("mid_rst_flags", RES_FLAGS, 0);
    @(negedge CLK);
    chk("mid_rst_no_res", RES_VALID, 0);

    // 16 completed ops wrap the 4-bit counter; the first op checks acc == 0
    issue(4'b0000, 16'hBEEF, 16'd5, 1'b1, lat);
    chk("acc_cleared", RES_DATA, 16'd5);
    @(negedge CLK);
    for (int i = 1; i < 16; i++) begin
      issue(4'b0000, 16'(i), 16'd1, 1'b0, lat);
      if (i == 15) chk("wrap_data", RES_DATA, 16'd16);
      @(negedge CLK);
      if (i == 14) chk("wrap_pre", OP_COUNT, 15);
    end
    chk("wrap_count", OP_COUNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
